// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the divider job feeder
package div_pkg;

    // Default operand/answer width; matches the divider's data_A/data_B/answer
    localparam int DIV_WIDTH = 10;

    // Feeder control states
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } feeder_state_e;

    // One result as presented to the consumer
    typedef struct packed {
        logic [DIV_WIDTH-1:0] q;
        logic                 ovf;
        logic                 dvz;
        logic                 err;
    } div_res_t;

    // Result produced when the watchdog gives up on the divider
    function automatic div_res_t watchdog_res();
        div_res_t r;
        r     = '0;
        r.err = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/job_fifo.sv
// rtl/job_fifo.sv - small register-based operand FIFO, pointers wrap mod DEPTH
module job_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Full/empty come from the registered count, so a pop never frees a slot
    // for a push in the same cycle
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        do_push = push && !full;
        do_pop  = pop && !empty;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/div_job_feeder.sv
// rtl/div_job_feeder.sv - operand FIFO + single-issue shell around the divider (watchdog: DIV_FEEDER_TIMEOUT_EN)
module div_job_feeder
    import div_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             div_sclr,
    output logic             div_start,
    output logic [WIDTH-1:0] div_data_a,
    output logic [WIDTH-1:0] div_data_b,
    input  logic             div_busy,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_answer,
    input  logic             div_ovf,
    input  logic             div_dvz,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic             out_ovf,
    output logic             out_dvz,
    output logic             out_err
);

    localparam int CNT_W = $clog2(DEPTH+1);

    feeder_state_e      state_q, state_d;
    logic [WIDTH-1:0]   data_a_q, data_a_d;
    logic [WIDTH-1:0]   data_b_q, data_b_d;
    div_res_t           res_q, res_d;
    logic               out_valid_q, out_valid_d;

    logic               push, pop;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [2*WIDTH-1:0] fifo_head;
    logic               drain;

`ifdef DIV_FEEDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT+1);
    logic [WD_W-1:0]    wd_q, wd_d;
`endif

    job_fifo #(
        .W     (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({in_a, in_b}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Producer side stays closed during INIT so nothing lands before the divider is cleared
    assign in_ready   = (state_q != ST_INIT) && (fifo_count != CNT_W'(DEPTH));
    assign push       = in_valid && in_ready && !fifo_full;
    assign drain      = out_valid_q && out_ready;

    assign div_data_a = data_a_q;
    assign div_data_b = data_b_q;
    assign out_valid  = out_valid_q;
    assign out_q      = res_q.q;
    assign out_ovf    = res_q.ovf;
    assign out_dvz    = res_q.dvz;
    assign out_err    = res_q.err;

    // Control FSM: issue one job at a time, capture its result, hold it for the consumer
    always_comb begin
        state_d     = state_q;
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;
        div_start   = 1'b0;
        div_sclr    = 1'b0;
`ifdef DIV_FEEDER_TIMEOUT_EN
        wd_d        = wd_q;
`endif
        if (drain) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_INIT: begin
                div_sclr = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                // A result being drained this cycle frees the output slot for the next job
                if (!fifo_empty && !div_busy && (!out_valid_q || out_ready)) begin
                    {data_a_d, data_b_d} = fifo_head;
                    state_d              = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                div_start = 1'b1;
                pop       = 1'b1;
                state_d   = ST_WAIT;
`ifdef DIV_FEEDER_TIMEOUT_EN
                wd_d      = '0;
`endif
            end
            ST_WAIT: begin
                if (div_valid) begin
                    res_d.q     = div_answer;
                    res_d.ovf   = div_ovf;
                    res_d.dvz   = div_dvz;
                    res_d.err   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
`ifdef DIV_FEEDER_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT)) begin
                    // Divider is presumed hung: report an error result and clear it
                    res_d       = watchdog_res();
                    out_valid_d = 1'b1;
                    div_sclr    = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            data_a_q    <= '0;
            data_b_q    <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef DIV_FEEDER_TIMEOUT_EN
    // Watchdog counter for WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

endmodule

// File: tb/tb_div_job_feeder.sv
// tb/tb_div_job_feeder.sv - scoreboard bench for div_job_feeder with a divider stub
module tb_div_job_feeder;

    localparam int W  = 10;
    localparam int D  = 4;
    localparam int TO = 64;

    typedef struct packed {
        logic [W-1:0] q;
        logic         ovf;
        logic         dvz;
        logic         err;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] in_a, in_b;
    logic         div_sclr, div_start;
    logic [W-1:0] div_data_a, div_data_b;
    logic         div_busy, div_valid;
    logic [W-1:0] div_answer;
    logic         div_ovf, div_dvz;
    logic         out_valid, out_ready;
    logic [W-1:0] out_q;
    logic         out_ovf, out_dvz, out_err;

    always #5 clk = ~clk;

    div_job_feeder #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .div_sclr   (div_sclr),
        .div_start  (div_start),
        .div_data_a (div_data_a),
        .div_data_b (div_data_b),
        .div_busy   (div_busy),
        .div_valid  (div_valid),
        .div_answer (div_answer),
        .div_ovf    (div_ovf),
        .div_dvz    (div_dvz),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q      (out_q),
        .out_ovf    (out_ovf),
        .out_dvz    (out_dvz),
        .out_err    (out_err)
    );

    int compared   = 0;
    int mismatched = 0;

    res_t         exp_q[$];
    logic [2*W-1:0] iss_q[$];

    int  ready_mode = 1;
    int  lat_cfg    = 12;
    bit  lat_rand   = 0;
    bit  hang_mode  = 0;
    bit  late_req   = 0;
    int  start_cnt  = 0;
    int  sclr_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Stub divider behaviour: unsigned quotient, all-ones with dvz on /0, ovf flagged on /1
    function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        r = '0;
        if (b == '0) begin
            r.q   = '1;
            r.dvz = 1'b1;
        end else begin
            r.q   = a / b;
            r.ovf = (b == W'(1));
        end
        return r;
    endfunction

    // Consumer ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Divider stub: busy for N cycles after start, then a one-cycle valid
    initial begin
        logic         s_start, s_sclr;
        logic [W-1:0] pa, pb;
        int           cnt;
        bit           hung;
        res_t         r;
        logic [2*W-1:0] e;
        div_busy = 0; div_valid = 0; div_answer = '0; div_ovf = 0; div_dvz = 0;
        pa = '0; pb = '0; cnt = 0; hung = 0;
        forever begin
            @(negedge clk);
            s_start = div_start;
            s_sclr  = div_sclr;
            if (rst_n && s_sclr) sclr_cnt++;
            if (rst_n && s_start) begin
                check("start_while_busy", 32'(div_busy), 32'd0);
                check("start_while_result_held", 32'(out_valid), 32'd0);
                if (iss_q.size() == 0) begin
                    check("unexpected_start", 32'd1, 32'd0);
                end else begin
                    e = iss_q.pop_front();
                    check("div_data", 32'({div_data_a, div_data_b}), 32'(e));
                end
                pa = div_data_a;
                pb = div_data_b;
            end
            @(posedge clk); #1;
            div_valid = 1'b0;
            if (s_sclr) begin
                div_busy = 1'b0;
                hung     = 0;
                cnt      = 0;
            end else if (s_start) begin
                div_busy = 1'b1;
                cnt      = lat_rand ? int'($urandom_range(1, 6)) : lat_cfg;
                hung     = hang_mode;
                start_cnt++;
            end else if (div_busy && !hung) begin
                cnt--;
                if (cnt == 0) begin
                    r          = ref_div(pa, pb);
                    div_busy   = 1'b0;
                    div_valid  = 1'b1;
                    div_answer = r.q;
                    div_ovf    = r.ovf;
                    div_dvz    = r.dvz;
                end
            end
            if (late_req) begin
                div_valid  = 1'b1;
                div_answer = W'(123);
            end
        end
    end

    // Output monitor: scoreboard compare, hold-while-stalled and capture latency
    initial begin
        logic pv, pf, pdv;
        res_t pres, e;
        pv = 0; pf = 0; pdv = 0; pres = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0; pf = 0; pdv = 0;
                continue;
            end
            if (pv && !pf) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'({out_q, out_ovf, out_dvz, out_err}), 32'(pres));
            end
            if (out_valid && !pv && !out_err) begin
                check("result_latency", 32'(pdv), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_q",   32'(out_q),   32'(e.q));
                    check("out_ovf", 32'(out_ovf), 32'(e.ovf));
                    check("out_dvz", 32'(out_dvz), 32'(e.dvz));
                    check("out_err", 32'(out_err), 32'(e.err));
                end
            end
            pv   = out_valid;
            pf   = out_valid && out_ready;
            pres = {out_q, out_ovf, out_dvz, out_err};
            pdv  = div_valid;
        end
    end

    task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b, input bit hang,
                            input int max_wait, output bit ok);
        res_t r;
        in_a = a; in_b = b; in_valid = 1'b1; ok = 0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                if (hang) begin
                    r = '0;
                    r.err = 1'b1;
                end else begin
                    r = ref_div(a, b);
                end
                exp_q.push_back(r);
                iss_q.push_back({a, b});
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_within_budget", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_out_valid(input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_within_budget", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_start(input int s0, input int max_cyc);
        int n;
        n = 0;
        while (start_cnt == s0 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check("start_within_budget", 32'(start_cnt != s0), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Main stimulus
    initial begin
        bit ok;
        int acc, s0, sc0;
        logic [W-1:0] a, b;
        int sel;
        bit seen_v, seen_s;

        rst_n = 0; in_valid = 0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_div_sclr",  32'(div_sclr),  32'd1);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_flags", 32'({out_q, out_ovf, out_dvz, out_err}), 32'd0);
        check("rst_div_data",  32'({div_data_a, div_data_b}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("init_sclr_high", 32'(div_sclr), 32'd1);
        check("init_in_ready",  32'(in_ready), 32'd0);
        @(negedge clk);
        check("idle_sclr_low",  32'(div_sclr), 32'd0);
        check("idle_in_ready",  32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // 100/7 with 12 busy cycles, check issue latency
        push_job(W'(100), W'(7), 0, 20, ok);
        check("accept_100_7", 32'(ok), 32'd1);
        @(negedge clk);
        check("no_start_same_cycle", 32'(div_start), 32'd0);
        @(negedge clk);
        check("start_next_cycle", 32'(div_start), 32'd1);
        wait_drain(100);

        // 5/0 with the consumer stalled
        ready_mode = 0;
        push_job(W'(5), W'(0), 0, 20, ok);
        wait_out_valid(60);
        repeat (5) @(negedge clk);
        check("dvz_held_valid", 32'(out_valid), 32'd1);
        check("dvz_flag", 32'(out_dvz), 32'd1);
        @(posedge clk); #1;
        ready_mode = 1;
        wait_drain(20);

        // Hold a result, then fill the FIFO: exactly DEPTH accepted
        ready_mode = 0;
        push_job(W'(9), W'(1), 0, 20, ok);
        wait_out_valid(60);
        lat_cfg = 3;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            push_job(W'(i * 37 + 9), W'(i + 2), 0, 3, ok);
            acc += int'(ok);
        end
        check("fifo_accepted", 32'(acc), 32'(D));
        @(negedge clk);
        check("in_ready_when_full", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        ready_mode = 1;
        push_job(W'(4 * 37 + 9), W'(6), 0, 60, ok);
        check("fifth_accepted_after_drain", 32'(ok), 32'd1);
        wait_drain(400);

        // Randomized traffic with random consumer stalls and divider latency
        ready_mode = 2;
        lat_rand   = 1;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            a   = W'($urandom);
            b   = (sel == 0) ? W'(0) : (sel == 1) ? W'(1) : W'($urandom_range(2, (1 << W) - 1));
            push_job(a, b, 0, 80, ok);
            check("rand_accept", 32'(ok), 32'd1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        wait_drain(1500);
        ready_mode = 1;
        lat_rand   = 0;
        lat_cfg    = 4;

        // Reset mid-WAIT with two jobs queued
        hang_mode = 1;
        s0 = start_cnt;
        push_job(W'(11), W'(3), 0, 20, ok);
        wait_start(s0, 20);
        repeat (3) begin
            @(posedge clk); #1;
        end
        push_job(W'(20), W'(4), 0, 20, ok);
        push_job(W'(30), W'(5), 0, 20, ok);
        rst_n = 0;
        @(negedge clk);
        check("mid_rst_in_ready",  32'(in_ready),  32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_div_start", 32'(div_start), 32'd0);
        check("mid_rst_div_sclr",  32'(div_sclr),  32'd1);
        exp_q.delete();
        iss_q.delete();
        hang_mode = 0;
        @(posedge clk); #1;
        rst_n = 1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        late_req = 1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        late_req = 0;
        seen_v = 0; seen_s = 0;
        repeat (10) begin
            @(negedge clk);
            seen_v |= out_valid;
            seen_s |= div_start;
        end
        check("late_valid_ignored", 32'(seen_v), 32'd0);
        check("fifo_empty_after_rst", 32'(seen_s), 32'd0);
        @(posedge clk); #1;
        push_job(W'(200), W'(9), 0, 20, ok);
        wait_drain(100);

`ifdef DIV_FEEDER_TIMEOUT_EN
        // Hung divider: watchdog result, one sclr pulse, next job runs normally
        hang_mode = 1;
        s0  = start_cnt;
        sc0 = sclr_cnt;
        push_job(W'(50), W'(5), 1, 20, ok);
        wait_start(s0, 20);
        hang_mode = 0;
        push_job(W'(60), W'(6), 0, 20, ok);
        wait_drain(400);
        check("wd_sclr_pulses", 32'(sclr_cnt - sc0), 32'd1);
`else
        sc0 = sclr_cnt;
        check("no_spurious_sclr", 32'(sclr_cnt - sc0), 32'd0);
`endif

        repeat (5) begin
            @(posedge clk); #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
